fp_mul_booth_seq: RTL and testbench
===================================

# fp_mul_booth_seq

Sequential radix-4 Booth mantissa multiplier for the single-precision FP multiplier. It accepts two 24-bit significands (hidden bit plus 23-bit fraction) over a valid/ready handshake and retires one Booth digit per cycle. It presents the exact 48-bit product `frc_Z_full` and `norm_n` to the downstream normalization stage. Exponent, sign, special-case and rounding logic stay outside this block.

## Interface
- `MW`, default 24: significand width including the hidden bit.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: operands valid.
- `in_ready`  out  1: block idle, able to accept operands.
- `hid_X`, `hid_Y`  in  1 each: hidden bits. The caller drives 0 for subnormal or zero operands.
- `frc_X`, `frc_Y`  in  MW-1 each: fraction fields.
- `out_valid`  out  1: product valid.
- `out_ready`  in  1: downstream accepts the product.
- `frc_Z_full`  out  2*MW: unsigned product `{hid_X,frc_X}*{hid_Y,frc_Y}`.
- `norm_n`  out  1: equals `frc_Z_full[2*MW-1]`.
- `busy`  out  1: asserted in RUN or DONE.

## Operation
- FSM has three states.
  - IDLE: `in_ready`=1. `in_valid`&&`in_ready` latches multiplicand M={2'b0,hid_X,frc_X} (MW+2 bits) and multiplier Q={1'b0,hid_Y,frc_Y,1'b0}. It clears accumulator P (2*MW+2 bits, two's complement) and counter k. Next state is RUN.
  - RUN: each cycle recodes triplet Q[2k+2:2k] into digit d∈{-2,-1,0,+1,+2}, then updates P += (d·M)<<2k and k++. After digit k=MW/2 (13 digits for MW=24), P[2*MW-1:0] loads into `frc_Z_full` and the next state is DONE.
  - DONE: `out_valid`=1. `out_ready`=1 moves to IDLE.
- Q zero-extension guarantees a nonnegative final product. P[2*MW+1:2*MW] must be 0 at DONE; the bench asserts this.
- Inputs are ignored outside IDLE. `in_valid` in RUN or DONE is not accepted.
- `frc_Z_full` and `norm_n` update only on entry to DONE and hold through backpressure and IDLE.
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `frc_Z_full`=0, `norm_n`=0. Reset state is IDLE; P, M, Q and k are 0.
- Reset mid-RUN or mid-DONE aborts the operation immediately. The pending product is discarded and no partial `out_valid` is produced.

## Timing
- Acceptance edge is E0. RUN occupies edges E1..E13. `out_valid` is high after E13, a latency of 13 cycles with MW=24.
- `out_valid`&&`out_ready` at edge En returns to IDLE. `in_ready` is high after En. Minimum spacing between acceptances is 15 cycles with zero backpressure.
- No combinational path exists from `in_valid` to `out_valid` or from `out_ready` to `in_ready`. `in_ready` is decoded from state only.

## Configuration
- `FP_MUL_BOOTH_EARLY_EXIT_EN` defined:
  - In IDLE, if either significand is all-zero, go directly to DONE with `frc_Z_full`=0. Latency is 1 cycle.
  - In RUN, when the remaining unrecoded multiplier bits Q[MW+1:2k+1] are all zero, load the product and go to DONE. All remaining digits are 0, so the result is bit-identical.
- Undefined: latency is fixed at MW/2+1 cycles for every operand, including zero.

## Structure
- Package `fp_mul_pkg` holds:
  - MW and BOOTH_DIGITS (=MW/2+1).
  - The state enum `booth_state_t` {IDLE, RUN, DONE}.
  - The Booth digit struct {neg, one, two}.
- Sub-module `fp_booth_r4_enc`: a combinational 3-bit triplet to {neg, one, two} encoder. It is instantiated once and indexed by k.
- Datapath, FSM and handshake live in `fp_mul_booth_seq`.

## Test plan
- 1.0×1.0: hid=1 and frc=0 on both operands -> `frc_Z_full`=48'h4000_0000_0000, `norm_n`=0, `out_valid` 13 cycles after acceptance.
- 1.5×1.5: frc=0x400000 on both operands -> `frc_Z_full`=48'h9000_0000_0000, `norm_n`=1.
- Max×max: frc=0x7FFFFF on both operands -> `frc_Z_full`=48'hFFFF_FE00_0001, `norm_n`=1, and P upper guard bits are 0.
- Subnormal X (hid_X=0, frc_X=0x000001) × 1.0 -> `frc_Z_full`=48'h0000_0080_0000, `norm_n`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE and drive `in_valid` with new operands -> `out_valid` and `frc_Z_full` stay stable, `in_ready`=0, and the new operands are not accepted. The first acceptance occurs the cycle after the `out_ready` handshake.
- Reset at RUN cycle 6 -> `out_valid`=0 and `in_ready`=1 after reset, and the next 1.5×1.5 returns 48'h9000_0000_0000. With `FP_MUL_BOOTH_EARLY_EXIT_EN`: 0×1.0 gives `out_valid` 1 cycle after acceptance with `frc_Z_full`=0.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared widths, FSM state and Booth digit encoding for the sequential
// radix-4 Booth significand multiplier.
package fp_mul_pkg;

  localparam int unsigned MW           = 24;
  localparam int unsigned BOOTH_DIGITS = MW / 2 + 1;
  localparam int unsigned PW           = 2 * MW + 2;
  // Multiplier register carries one extra zero on top so the last triplet stays in range
  localparam int unsigned QW           = MW + 3;
  localparam int unsigned KW           = $clog2(BOOTH_DIGITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } booth_state_t;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

endpackage

// File: rtl/fp_mul_booth_seq_if.sv
// Operand/product handshake bundle between the FP multiplier control and
// the sequential Booth significand multiplier.
interface fp_mul_booth_seq_if;

  logic                            in_valid;
  logic                            in_ready;
  logic                            hid_X;
  logic                            hid_Y;
  logic [fp_mul_pkg::MW-2:0]       frc_X;
  logic [fp_mul_pkg::MW-2:0]       frc_Y;
  logic                            out_valid;
  logic                            out_ready;
  logic [2*fp_mul_pkg::MW-1:0]     frc_Z_full;
  logic                            norm_n;
  logic                            busy;

  modport master (
    output in_valid, hid_X, hid_Y, frc_X, frc_Y, out_ready,
    input  in_ready, out_valid, frc_Z_full, norm_n, busy
  );

  modport slave (
    input  in_valid, hid_X, hid_Y, frc_X, frc_Y, out_ready,
    output in_ready, out_valid, frc_Z_full, norm_n, busy
  );

endinterface

// File: rtl/fp_booth_r4_enc.sv
// Radix-4 Booth recoder: multiplier triplet {b2,b1,b0} to digit in {-2..+2}.
module fp_booth_r4_enc
  import fp_mul_pkg::*;
(
  input  logic [2:0]   trip_i,
  output booth_digit_t dig_c_o
);

  // 111 and 000 both give zero, so neg is suppressed for 111
  assign dig_c_o.neg = trip_i[2] & ~(trip_i[1] & trip_i[0]);
  assign dig_c_o.one = trip_i[1] ^ trip_i[0];
  assign dig_c_o.two = (trip_i[2] & ~trip_i[1] & ~trip_i[0]) |
                       (~trip_i[2] & trip_i[1] & trip_i[0]);

endmodule

// File: rtl/fp_mul_booth_seq.sv
// Sequential radix-4 Booth 24x24 significand multiplier, one digit per cycle.
// Optional FP_MUL_BOOTH_EARLY_EXIT_EN: skip work for zero operands / exhausted multiplier.
module fp_mul_booth_seq
  import fp_mul_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  fp_mul_booth_seq_if.slave  bus
);

  booth_state_t      state_q;
  logic [MW+1:0]     m_q;
  logic [QW-1:0]     q_q;
  logic [PW-1:0]     p_q;
  logic [KW-1:0]     k_q;
  logic [2*MW-1:0]   frc_z_q;
  logic              norm_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;

  logic [2:0]        trip_c;
  booth_digit_t      dig_c;
  logic [4:0]        sh_c;
  logic [PW-1:0]     pp_mag_c;
  logic [PW-1:0]     pp_c;
  logic [PW-1:0]     p_d;
  logic              last_c;
  logic              run_exit_c;

  assign sh_c   = {k_q, 1'b0};
  assign trip_c = q_q[sh_c +: 3];

  fp_booth_r4_enc u_enc (
    .trip_i  (trip_c),
    .dig_c_o (dig_c)
  );

  // Signed partial product d*M, weighted by 4^k
  assign pp_mag_c = dig_c.two ? PW'({m_q, 1'b0}) :
                    dig_c.one ? PW'(m_q) : '0;
  assign pp_c     = dig_c.neg ? (~pp_mag_c + PW'(1)) : pp_mag_c;
  assign p_d      = p_q + (pp_c << sh_c);
  assign last_c   = (k_q == KW'(BOOTH_DIGITS - 1));

`ifdef FP_MUL_BOOTH_EARLY_EXIT_EN
  logic [5:0] rest_sh_c;
  logic       rest_zero_c;
  logic       op_zero_c;

  assign rest_sh_c   = {1'b0, k_q, 1'b0} + 6'd1;
  assign rest_zero_c = ((q_q >> rest_sh_c) == '0);
  assign run_exit_c  = last_c | rest_zero_c;
  assign op_zero_c   = ({bus.hid_X, bus.frc_X} == '0) | ({bus.hid_Y, bus.frc_Y} == '0);
`else
  assign run_exit_c  = last_c;
`endif

  // Control, datapath and handshake registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      m_q         <= '0;
      q_q         <= '0;
      p_q         <= '0;
      k_q         <= '0;
      frc_z_q     <= '0;
      norm_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            m_q        <= {2'b00, bus.hid_X, bus.frc_X};
            q_q        <= {2'b00, bus.hid_Y, bus.frc_Y, 1'b0};
            p_q        <= '0;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef FP_MUL_BOOTH_EARLY_EXIT_EN
            if (op_zero_c) begin
              frc_z_q     <= '0;
              norm_q      <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q     <= RUN;
            end
`else
            state_q    <= RUN;
`endif
          end
        end
        RUN: begin
          p_q <= p_d;
          k_q <= k_q + KW'(1);
          if (run_exit_c) begin
            frc_z_q     <= p_d[2*MW-1:0];
            norm_q      <= p_d[2*MW-1];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frc_Z_full = frc_z_q;
  assign bus.norm_n     = norm_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_fp_mul_booth_seq.sv
// Directed/random bench for fp_mul_booth_seq with a product scoreboard.
// Honours FP_MUL_BOOTH_EARLY_EXIT_EN for latency expectations.
module tb_fp_mul_booth_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_mul_booth_seq_if bus ();

  fp_mul_booth_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [47:0] prod;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one operand pair and record its expected product; caller sits at posedge+1
  task automatic send(input logic hx, input logic [22:0] fx,
                      input logic hy, input logic [22:0] fy, input bit track);
    exp_t e;
    e.prod = 48'({hx, fx}) * 48'({hy, fy});
`ifdef FP_MUL_BOOTH_EARLY_EXIT_EN
    e.lat  = (({hx, fx} == 24'd0) || ({hy, fy} == 24'd0)) ? 1 : -1;
`else
    e.lat  = 13;
`endif
    if (track) sb.push_back(e);
    chk("in_ready_before_send", 64'(bus.in_ready), 64'd1);
    bus.hid_X    = hx;
    bus.frc_X    = fx;
    bus.hid_Y    = hy;
    bus.frc_Y    = fy;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait for out_valid, then compare against the scoreboard head
  task automatic wait_out();
    exp_t e;
    int   cyc  = 0;
    bit   seen = 1'b0;
    while (cyc < 40 && !seen) begin
      @(posedge clk); #1;
      cyc++;
      seen = bus.out_valid;
    end
    chk("out_valid_timeout", 64'(seen), 64'd1);
    chk("scoreboard_nonempty", 64'(sb.size() > 0), 64'd1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      if (e.lat >= 0) chk("latency", 64'(cyc), 64'(e.lat));
      chk("frc_Z_full", 64'(bus.frc_Z_full), 64'(e.prod));
      chk("norm_n", 64'(bus.norm_n), 64'(e.prod[47]));
      chk("p_guard_bits", 64'(dut.p_q[49:48]), 64'd0);
      chk("busy_done", 64'(bus.busy), 64'd1);
      chk("in_ready_done", 64'(bus.in_ready), 64'd0);
    end
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("out_valid_after_take", 64'(bus.out_valid), 64'd0);
    chk("in_ready_after_take", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    logic [47:0] held;
    bit          stray;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.hid_X     = 1'b0;
    bus.hid_Y     = 1'b0;
    bus.frc_X     = '0;
    bus.frc_Y     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_frc_Z_full", 64'(bus.frc_Z_full), 64'd0);
    chk("rst_norm_n", 64'(bus.norm_n), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1.0 x 1.0
    send(1'b1, 23'h000000, 1'b1, 23'h000000, 1'b1);
    wait_out();
    chk("one_x_one_const", 64'(bus.frc_Z_full), 64'h4000_0000_0000);
    take();

    // 1.5 x 1.5
    send(1'b1, 23'h400000, 1'b1, 23'h400000, 1'b1);
    wait_out();
    chk("onefive_const", 64'(bus.frc_Z_full), 64'h9000_0000_0000);
    take();

    // max x max
    send(1'b1, 23'h7FFFFF, 1'b1, 23'h7FFFFF, 1'b1);
    wait_out();
    chk("max_const", 64'(bus.frc_Z_full), 64'hFFFF_FE00_0001);
    take();

    // subnormal X x 1.0
    send(1'b0, 23'h000001, 1'b1, 23'h000000, 1'b1);
    wait_out();
    chk("subnormal_const", 64'(bus.frc_Z_full), 64'h0000_0080_0000);
    take();

    // Random operands
    for (int i = 0; i < 6; i++) begin
      send(1'($urandom), 23'($urandom), 1'($urandom), 23'($urandom), 1'b1);
      wait_out();
      take();
    end

    // Backpressure with competing input request
    send(1'b1, 23'h123456, 1'b1, 23'h654321, 1'b1);
    wait_out();
    held          = bus.frc_Z_full;
    bus.hid_X     = 1'b1;
    bus.frc_X     = 23'h400000;
    bus.hid_Y     = 1'b1;
    bus.frc_Y     = 23'h000000;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_frc_hold", 64'(bus.frc_Z_full), 64'(held));
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_in_ready_after", 64'(bus.in_ready), 64'd1);
    chk("bp_frc_hold_idle", 64'(bus.frc_Z_full), 64'(held));
    send(1'b1, 23'h400000, 1'b1, 23'h000000, 1'b1);
    wait_out();
    take();

    // Reset in the middle of RUN
    send(1'b1, 23'h400000, 1'b1, 23'h400000, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrun_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrun_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrun_rst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) stray = 1'b1;
    end
    chk("no_stray_out_valid", 64'(stray), 64'd0);
    send(1'b1, 23'h400000, 1'b1, 23'h400000, 1'b1);
    wait_out();
    chk("post_rst_const", 64'(bus.frc_Z_full), 64'h9000_0000_0000);
    take();

    // Zero operand
    send(1'b0, 23'h000000, 1'b1, 23'h000000, 1'b1);
    wait_out();
    take();

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
